router_iact_mc: RTL and testbench

- Parametrised successor to the west-side iact router.
- Accepts iact words from four mesh inputs (N, S, W, E) and from a built-in GLB burst-fetch engine.
- Buffers them in a FIFO and multicasts each word to any subset of {north, south, east, local spad}, set by a destination mask.
- Adds valid/ready backpressure, round-robin input arbitration, buffering and eager-fork multicast. The current router has none of these.

---
 rtl/router_iact_pkg.sv | 31 +++
 rtl/iact_fifo.sv | 51 +++++
 rtl/router_iact_mc.sv | 153 +++++++++++++++
 tb/tb_router_iact_mc.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_iact_pkg.sv
// Shared constants for the multicast iact router: destination/source indices,
// fetch FSM encoding and a constant-evaluable clog2.
package router_iact_pkg;

   localparam int DST_N    = 0;
   localparam int DST_S    = 1;
   localparam int DST_E    = 2;
   localparam int DST_SPAD = 3;

   localparam int SRC_N = 0;
   localparam int SRC_S = 1;
   localparam int SRC_W = 2;
   localparam int SRC_E = 3;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/iact_fifo.sv
// Synchronous FIFO holding {data, dest_mask} words; push while full is
// accepted only when a pop happens in the same cycle.
module iact_fifo
   import router_iact_pkg::*;
#(
   parameter int WIDTH = 20,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1,
   localparam int CW = clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (!do_push && do_pop) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/router_iact_mc.sv
// Multicast iact router: round-robin mesh arbitration plus a GLB burst-fetch
// engine feeding one FIFO whose head is eagerly forked to N/S/E/spad.
module router_iact_mc
   import router_iact_pkg::*;
#(
   parameter int DATA_BITWIDTH     = 16,
   parameter int ADDR_BITWIDTH_GLB = 10,
   parameter int FIFO_DEPTH        = 4,
   parameter int BURST_LEN         = 25,
   parameter int A_READ_ADDR       = 100
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [3:0]                   dest_mask,
   input  logic [4*DATA_BITWIDTH-1:0]   in_data,
   input  logic [3:0]                   in_valid,
   output logic [3:0]                   in_ready,
   output logic [DATA_BITWIDTH-1:0]     north_data_o,
   output logic [DATA_BITWIDTH-1:0]     south_data_o,
   output logic [DATA_BITWIDTH-1:0]     east_data_o,
   output logic                         north_valid_o,
   output logic                         south_valid_o,
   output logic                         east_valid_o,
   input  logic                         north_ready_i,
   input  logic                         south_ready_i,
   input  logic                         east_ready_i,
   output logic [DATA_BITWIDTH-1:0]     spad_data_o,
   output logic                         spad_load_en_o,
   input  logic                         fetch_start,
   output logic [ADDR_BITWIDTH_GLB-1:0] glb_addr_o,
   output logic                         glb_req_o,
   input  logic [DATA_BITWIDTH-1:0]     glb_data_i,
   output logic                         fetch_busy,
   output logic                         fetch_done
);

   localparam int CNT_W = clog2(FIFO_DEPTH) + 1;
   localparam int ISS_W = clog2(BURST_LEN + 1);
   localparam int FW    = DATA_BITWIDTH + 4;

   logic [1:0]                   state;
   logic [ADDR_BITWIDTH_GLB-1:0] addr;
   logic [ISS_W-1:0]             issued;
   logic                         rsp_vld_p1;
   logic [1:0]                   rr_ptr;
   logic [3:0]                   sent;

   logic                     fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [CNT_W-1:0]         fifo_count;
   logic [FW-1:0]            push_word, head_word;
   logic [DATA_BITWIDTH-1:0] head_data, mesh_data;
   logic [3:0]               head_mask, dst_valid, dst_ready, dst_done;
   logic [3:0]               grant;
   logic [1:0]               grant_idx, idx;
   logic                     found, mesh_en, glb_req;

   iact_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .wdata (push_word),
      .pop   (fifo_pop),
      .rdata (head_word),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Eager fork: each destination fires once per head word, pop when all masked ones are done
   assign head_mask = head_word[3:0];
   assign head_data = fifo_empty ? '0 : head_word[FW-1:4];
   assign dst_valid = {4{~fifo_empty}} & head_mask & ~sent;
   assign dst_ready = {1'b1, east_ready_i, south_ready_i, north_ready_i};
   assign dst_done  = dst_valid & dst_ready;
   assign fifo_pop  = ~fifo_empty && ((head_mask & ~(sent | dst_done)) == 4'b0000);

   // Mesh grants are held off during reset so in_ready reads 0 like every other output
   assign mesh_en = reset && (state == ST_IDLE) && !rsp_vld_p1 && (!fifo_full || fifo_pop);

   always_comb begin
      grant     = '0;
      grant_idx = rr_ptr;
      mesh_data = '0;
      found     = 1'b0;
      idx       = '0;
      for (int k = 0; k < 4; k++) begin
         idx = rr_ptr + 2'(k);
         if (mesh_en && !found && in_valid[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            grant_idx  = idx;
            mesh_data  = in_data[32'(idx)*DATA_BITWIDTH +: DATA_BITWIDTH];
         end
      end
   end

   assign in_ready  = grant;
   assign fifo_push = rsp_vld_p1 | (|grant);
   assign push_word = rsp_vld_p1 ? {glb_data_i, dest_mask} : {mesh_data, dest_mask};

   // Credit check on registered count plus the one response that may be in flight
   assign glb_req = (state == ST_FETCH) &&
                    ((int'(fifo_count) + int'(rsp_vld_p1)) < FIFO_DEPTH);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         addr       <= '0;
         issued     <= '0;
         rsp_vld_p1 <= 1'b0;
         rr_ptr     <= '0;
         sent       <= '0;
      end else begin
         rsp_vld_p1 <= glb_req;
         if (|grant) rr_ptr <= grant_idx + 2'd1;
         sent <= fifo_pop ? 4'b0000 : (sent | dst_done);
         case (state)
            ST_IDLE: begin
               if (fetch_start) begin
                  state  <= ST_FETCH;
                  addr   <= ADDR_BITWIDTH_GLB'(A_READ_ADDR);
                  issued <= '0;
               end
            end
            ST_FETCH: begin
               if (glb_req) begin
                  addr   <= addr + ADDR_BITWIDTH_GLB'(1);
                  issued <= issued + ISS_W'(1);
                  if (issued == ISS_W'(BURST_LEN - 1)) state <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (rsp_vld_p1) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign north_data_o   = head_data;
   assign south_data_o   = head_data;
   assign east_data_o    = head_data;
   assign spad_data_o    = head_data;
   assign north_valid_o  = dst_valid[DST_N];
   assign south_valid_o  = dst_valid[DST_S];
   assign east_valid_o   = dst_valid[DST_E];
   assign spad_load_en_o = dst_valid[DST_SPAD];
   assign glb_addr_o     = addr;
   assign glb_req_o      = glb_req;
   assign fetch_busy     = (state != ST_IDLE);
   assign fetch_done     = (state == ST_DRAIN) && rsp_vld_p1;

endmodule

// File: tb/tb_router_iact_mc.sv
// Directed bench for router_iact_mc: fork, round-robin, full FIFO, GLB bursts
// (normal and address-wrapping instance) and reset during a burst.
module tb_router_iact_mc;

   localparam int DW = 16;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [3:0]    dest_mask = 4'b0000;
   logic [4*DW-1:0] in_data = '0;
   logic [3:0]    in_valid = 4'b0000;
   logic [3:0]    in_valid2 = 4'b0000;
   logic          north_ready_i = 1'b0, south_ready_i = 1'b0, east_ready_i = 1'b0;
   logic          fetch_start = 1'b0, fetch_start2 = 1'b0;
   logic [DW-1:0] glb_data_i, glb_data2;

   logic [3:0]    in_ready, in_ready2;
   logic [DW-1:0] north_data_o, south_data_o, east_data_o, spad_data_o;
   logic          north_valid_o, south_valid_o, east_valid_o, spad_load_en_o;
   logic [AW-1:0] glb_addr_o, glb_addr2;
   logic          glb_req_o, glb_req2, fetch_busy, fetch_busy2, fetch_done, fetch_done2;
   logic [DW-1:0] n_data2, s_data2, e_data2, spad_data2;
   logic          n_vld2, s_vld2, e_vld2, spad_en2;

   int n_checks = 0;
   int n_pass = 0;
   logic sel = 1'b0;

   logic [84:0]   outs1;
   logic          f_req, f_en, f_done, f_busy;
   logic [AW-1:0] f_addr;
   logic [DW-1:0] f_sdata;
   logic [3:0]    f_rdy;

   assign outs1 = {in_ready, north_valid_o, south_valid_o, east_valid_o, spad_load_en_o,
                   glb_req_o, fetch_busy, fetch_done, north_data_o, south_data_o,
                   east_data_o, spad_data_o, glb_addr_o};
   assign f_req   = sel ? glb_req2    : glb_req_o;
   assign f_addr  = sel ? glb_addr2   : glb_addr_o;
   assign f_en    = sel ? spad_en2    : spad_load_en_o;
   assign f_sdata = sel ? spad_data2  : spad_data_o;
   assign f_done  = sel ? fetch_done2 : fetch_done;
   assign f_busy  = sel ? fetch_busy2 : fetch_busy;
   assign f_rdy   = sel ? in_ready2   : in_ready;

   router_iact_mc dut (
      .clk(clk), .reset(reset), .dest_mask(dest_mask), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready),
      .north_data_o(north_data_o), .south_data_o(south_data_o), .east_data_o(east_data_o),
      .north_valid_o(north_valid_o), .south_valid_o(south_valid_o), .east_valid_o(east_valid_o),
      .north_ready_i(north_ready_i), .south_ready_i(south_ready_i), .east_ready_i(east_ready_i),
      .spad_data_o(spad_data_o), .spad_load_en_o(spad_load_en_o), .fetch_start(fetch_start),
      .glb_addr_o(glb_addr_o), .glb_req_o(glb_req_o), .glb_data_i(glb_data_i),
      .fetch_busy(fetch_busy), .fetch_done(fetch_done)
   );

   router_iact_mc #(.A_READ_ADDR(1020)) dut_wrap (
      .clk(clk), .reset(reset), .dest_mask(dest_mask), .in_data(in_data),
      .in_valid(in_valid2), .in_ready(in_ready2),
      .north_data_o(n_data2), .south_data_o(s_data2), .east_data_o(e_data2),
      .north_valid_o(n_vld2), .south_valid_o(s_vld2), .east_valid_o(e_vld2),
      .north_ready_i(north_ready_i), .south_ready_i(south_ready_i), .east_ready_i(east_ready_i),
      .spad_data_o(spad_data2), .spad_load_en_o(spad_en2), .fetch_start(fetch_start2),
      .glb_addr_o(glb_addr2), .glb_req_o(glb_req2), .glb_data_i(glb_data2),
      .fetch_busy(fetch_busy2), .fetch_done(fetch_done2)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] glb_model(input logic [AW-1:0] a);
      return {6'h2A, a};
   endfunction

   // GLB memory model: data returned one cycle after each request
   always @(posedge clk) begin
      glb_data_i <= glb_req_o ? glb_model(glb_addr_o) : '0;
      glb_data2  <= glb_req2  ? glb_model(glb_addr2)  : '0;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      in_valid = 4'hF;
      @(negedge clk); @(negedge clk); #1;
      n_checks++; if (outs1 !== '0) $display("FAIL reset_outputs: got %h want 0", outs1); else n_pass++;
      n_checks++; if (fetch_busy2 !== 1'b0) $display("FAIL reset_busy2: got %b want 0", fetch_busy2); else n_pass++;
      @(negedge clk); in_valid = 4'h0; reset = 1'b1;
   endtask

   task automatic test_single();
      @(negedge clk);
      dest_mask = 4'b0001; in_data[15:0] = 16'h0005; in_valid = 4'b0001; north_ready_i = 1'b0;
      #1;
      n_checks++; if (in_ready !== 4'b0001) $display("FAIL single_in_ready: got %b want 0001", in_ready); else n_pass++;
      @(negedge clk); in_valid = 4'b0000; #1;
      n_checks++; if (north_valid_o !== 1'b1 || north_data_o !== 16'h0005)
         $display("FAIL single_north: got v=%b d=%h want v=1 d=0005", north_valid_o, north_data_o); else n_pass++;
      n_checks++; if ({south_valid_o, east_valid_o, spad_load_en_o} !== 3'b000)
         $display("FAIL single_others: got %b want 000", {south_valid_o, east_valid_o, spad_load_en_o}); else n_pass++;
      @(negedge clk); north_ready_i = 1'b1; #1;
      n_checks++; if (north_valid_o !== 1'b1) $display("FAIL single_hold: got %b want 1", north_valid_o); else n_pass++;
      @(negedge clk); north_ready_i = 1'b0; #1;
      n_checks++; if (north_valid_o !== 1'b0 || north_data_o !== 16'h0000)
         $display("FAIL single_popped: got v=%b d=%h want v=0 d=0000", north_valid_o, north_data_o); else n_pass++;
   endtask

   task automatic test_multicast();
      int strobes;
      strobes = 0;
      @(negedge clk);
      dest_mask = 4'b1110; in_data[31:16] = 16'h0011; in_valid = 4'b0010; #1;
      n_checks++; if (in_ready !== 4'b0010) $display("FAIL mc_in_ready: got %b want 0010", in_ready); else n_pass++;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         in_valid = 4'b0000; south_ready_i = 1'b1; east_ready_i = (c == 4);
         #1;
         if (spad_load_en_o) strobes++;
         n_checks++; if (east_valid_o !== 1'b1 || east_data_o !== 16'h0011)
            $display("FAIL mc_east_c%0d: got v=%b d=%h want v=1 d=0011", c, east_valid_o, east_data_o); else n_pass++;
         n_checks++; if (south_valid_o !== (c == 1))
            $display("FAIL mc_south_c%0d: got %b want %b", c, south_valid_o, (c == 1)); else n_pass++;
      end
      @(negedge clk); east_ready_i = 1'b0; south_ready_i = 1'b0; #1;
      n_checks++; if (strobes != 1) $display("FAIL mc_spad_strobes: got %0d want 1", strobes); else n_pass++;
      n_checks++; if ({north_valid_o, south_valid_o, east_valid_o, spad_load_en_o} !== 4'b0000)
         $display("FAIL mc_popped: got %b want 0000", {north_valid_o, south_valid_o, east_valid_o, spad_load_en_o}); else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [3:0]    exp_g;
      logic [DW-1:0] exp_d;
      @(negedge clk); reset = 1'b0;
      @(negedge clk); reset = 1'b1;
      dest_mask = 4'b1000;
      in_data = {16'h0A03, 16'h0A02, 16'h0A01, 16'h0A00};
      for (int k = 0; k < 8; k++) begin
         @(negedge clk); in_valid = 4'hF; #1;
         exp_g = 4'(1 << (k % 4));
         n_checks++; if (in_ready !== exp_g) $display("FAIL rr_grant_%0d: got %b want %b", k, in_ready, exp_g); else n_pass++;
         if (k > 0) begin
            exp_d = 16'h0A00 + 16'((k - 1) % 4);
            n_checks++; if (spad_load_en_o !== 1'b1 || spad_data_o !== exp_d)
               $display("FAIL rr_spad_%0d: got en=%b d=%h want en=1 d=%h", k, spad_load_en_o, spad_data_o, exp_d); else n_pass++;
         end
      end
      @(negedge clk); in_valid = 4'h0; #1;
      n_checks++; if (spad_load_en_o !== 1'b1 || spad_data_o !== 16'h0A03)
         $display("FAIL rr_last: got en=%b d=%h want en=1 d=0a03", spad_load_en_o, spad_data_o); else n_pass++;
      @(negedge clk); #1;
      n_checks++; if (spad_load_en_o !== 1'b0) $display("FAIL rr_empty: got %b want 0", spad_load_en_o); else n_pass++;
   endtask

   task automatic test_full();
      logic [DW-1:0] exp_d;
      dest_mask = 4'b0001; north_ready_i = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk); in_valid = 4'b0001; in_data[15:0] = 16'h0B00 + 16'(k); #1;
         n_checks++; if (in_ready !== 4'b0001) $display("FAIL full_push_%0d: got %b want 0001", k, in_ready); else n_pass++;
      end
      @(negedge clk); in_data[15:0] = 16'h0B04; #1;
      n_checks++; if (in_ready !== 4'b0000) $display("FAIL full_blocked: got %b want 0000", in_ready); else n_pass++;
      n_checks++; if (north_valid_o !== 1'b1 || north_data_o !== 16'h0B00)
         $display("FAIL full_head: got v=%b d=%h want v=1 d=0b00", north_valid_o, north_data_o); else n_pass++;
      @(negedge clk); north_ready_i = 1'b1; #1;
      n_checks++; if (in_ready !== 4'b0001) $display("FAIL full_push_pop: got %b want 0001", in_ready); else n_pass++;
      @(negedge clk); north_ready_i = 1'b0; #1;
      n_checks++; if (in_ready !== 4'b0000) $display("FAIL full_still_full: got %b want 0000", in_ready); else n_pass++;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); in_valid = 4'b0000; north_ready_i = 1'b1; #1;
         exp_d = 16'h0B00 + 16'(k);
         n_checks++; if (north_valid_o !== 1'b1 || north_data_o !== exp_d)
            $display("FAIL full_drain_%0d: got v=%b d=%h want v=1 d=%h", k, north_valid_o, north_data_o, exp_d); else n_pass++;
      end
      @(negedge clk); north_ready_i = 1'b0; #1;
      n_checks++; if (north_valid_o !== 1'b0) $display("FAIL full_empty: got %b want 0", north_valid_o); else n_pass++;
   endtask

   task automatic test_fetch(input logic s, input int base);
      int nreq, nstb, ndone, bad, cyc, post;
      logic done_seen;
      logic [AW-1:0] ea;
      logic [3:0] v;
      nreq = 0; nstb = 0; ndone = 0; bad = 0; cyc = 0; post = 0; done_seen = 1'b0;
      sel = s; dest_mask = 4'b1000;
      while (post < 3 && cyc < 200) begin
         @(negedge clk);
         if (s) fetch_start2 = (cyc == 0); else fetch_start = (cyc == 0);
         v = (cyc > 0 && !done_seen) ? 4'hF : 4'h0;
         if (s) in_valid2 = v; else in_valid = v;
         #1;
         if (cyc > 0 && !done_seen && (f_rdy !== 4'h0 || f_busy !== 1'b1)) bad++;
         if (f_req) begin
            ea = AW'(base + nreq);
            n_checks++; if (f_addr !== ea) $display("FAIL fetch%0d_addr_%0d: got %0d want %0d", s, nreq, f_addr, ea); else n_pass++;
            nreq++;
         end
         if (f_en) begin
            ea = AW'(base + nstb);
            n_checks++; if (f_sdata !== glb_model(ea))
               $display("FAIL fetch%0d_data_%0d: got %h want %h", s, nstb, f_sdata, glb_model(ea)); else n_pass++;
            nstb++;
         end
         if (f_done) begin ndone++; done_seen = 1'b1; end
         if (done_seen) post++;
         cyc++;
      end
      n_checks++; if (nreq != 25) $display("FAIL fetch%0d_nreq: got %0d want 25", s, nreq); else n_pass++;
      n_checks++; if (nstb != 25) $display("FAIL fetch%0d_nstrobe: got %0d want 25", s, nstb); else n_pass++;
      n_checks++; if (ndone != 1) $display("FAIL fetch%0d_done: got %0d want 1", s, ndone); else n_pass++;
      n_checks++; if (bad != 0) $display("FAIL fetch%0d_ready_busy: got %0d bad cycles want 0", s, bad); else n_pass++;
      n_checks++; if (f_busy !== 1'b0) $display("FAIL fetch%0d_idle: got %b want 0", s, f_busy); else n_pass++;
      sel = 1'b0;
   endtask

   task automatic test_reset_mid_burst();
      int nreq, cyc, ndone;
      sel = 1'b0; dest_mask = 4'b1000; nreq = 0; cyc = 0; ndone = 0;
      @(negedge clk); fetch_start = 1'b1; #1;
      while (nreq < 10 && cyc < 100) begin
         @(negedge clk); fetch_start = 1'b0; #1;
         if (glb_req_o) nreq++;
         cyc++;
      end
      n_checks++; if (nreq != 10) $display("FAIL mid_nreq: got %0d want 10", nreq); else n_pass++;
      #1; in_valid = 4'hF; reset = 1'b0; #1;
      n_checks++; if (outs1 !== '0) $display("FAIL mid_reset_outputs: got %h want 0", outs1); else n_pass++;
      @(negedge clk); in_valid = 4'h0; reset = 1'b1; #1;
      for (int k = 0; k < 2; k++) begin
         n_checks++; if ({fetch_busy, spad_load_en_o, glb_req_o, fetch_done} !== 4'b0000)
            $display("FAIL mid_after_release_%0d: got %b want 0000", k, {fetch_busy, spad_load_en_o, glb_req_o, fetch_done}); else n_pass++;
         @(negedge clk); #1;
      end
      fetch_start = 1'b1;
      @(negedge clk); fetch_start = 1'b0; #1;
      n_checks++; if (glb_req_o !== 1'b1 || glb_addr_o !== 10'd100)
         $display("FAIL mid_restart: got req=%b addr=%0d want req=1 addr=100", glb_req_o, glb_addr_o); else n_pass++;
      cyc = 0;
      while (ndone == 0 && cyc < 200) begin
         @(negedge clk); #1;
         if (fetch_done) ndone++;
         cyc++;
      end
      n_checks++; if (ndone != 1) $display("FAIL mid_restart_done: got %0d want 1", ndone); else n_pass++;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_single();
      test_multicast();
      test_round_robin();
      test_full();
      test_fetch(1'b0, 100);
      test_fetch(1'b1, 1020);
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
